// File: rtl/disp_page_sched.sv
// Double-buffer page scheduler: the only master on the display register bus.
// After START it brings the display up, then swaps front/back VRAM pages at VBLANK on each flip request.
module disp_page_sched #(
  parameter logic [31:0] BASE_ADDR = 32'h2000_0000,
  parameter logic [15:0] POLL_MAX  = 16'd65535
) (
  input  logic        ACLK,
  input  logic        ARST,
  input  logic [1:0]  RESOL,
  input  logic        START,
  input  logic        FLIP_REQ,
  output logic        FLIP_BUSY,
  output logic        FLIP_DONE,
  output logic        TIMEOUT,
  output logic        DISP_PAGE,
  output logic [31:0] DRAW_ADDR,
  output logic [15:0] WRADDR,
  output logic [3:0]  BYTEEN,
  output logic        WREN,
  output logic [31:0] WDATA,
  output logic [15:0] RDADDR,
  output logic        RDEN,
  input  logic [31:0] RDATA
);

  localparam logic [15:0] REG_DISPADDR = 16'h0000;
  localparam logic [15:0] REG_DISPCTRL = 16'h0004;
  localparam logic [15:0] REG_DISPINT  = 16'h0008;
  localparam logic [15:0] REG_DISPFIFO = 16'h000C;

  localparam logic [31:0] PSZ_VGA  = 32'h0012_C000;
  localparam logic [31:0] PSZ_XGA  = 32'h0030_0000;
  localparam logic [31:0] PSZ_SXGA = 32'h0050_0000;

  typedef enum logic [3:0] {
    S_IDLE,
    S_INIT_ADDR,
    S_INIT_CTRL,
    S_INIT_INT,
    S_INIT_FIFO,
    S_READY,
    S_CLR_VB,
    S_POLL,
    S_WR_ADDR,
    S_DONE
  } state_t;

  state_t      state;
  logic [1:0]  phase;
  logic [31:0] psz;
  logic        pending;
  logic        vb_seen;
  logic [15:0] poll_cnt;
  logic        flip_active;
  logic [31:0] page1_addr;
  logic        unused_rdata;

  // Flip requests arriving while a flip is in flight are remembered one deep.
  assign flip_active  = (state == S_CLR_VB) || (state == S_POLL) ||
                        (state == S_WR_ADDR) || (state == S_DONE);
  assign page1_addr   = BASE_ADDR + psz;
  assign unused_rdata = ^{RDATA[31:2], RDATA[0]};

  function automatic logic [31:0] psz_of(input logic [1:0] resol);
    case (resol)
      2'b01:   return PSZ_XGA;
      2'b10:   return PSZ_SXGA;
      default: return PSZ_VGA;
    endcase
  endfunction

  // Every bus write occupies two cycles: strobe, then a mandatory idle cycle (phase 0/1).
  always_ff @(posedge ACLK) begin
    if (ARST) begin
      state     <= S_IDLE;
      phase     <= 2'd0;
      psz       <= 32'h0;
      pending   <= 1'b0;
      vb_seen   <= 1'b0;
      poll_cnt  <= 16'h0;
      FLIP_BUSY <= 1'b0;
      FLIP_DONE <= 1'b0;
      TIMEOUT   <= 1'b0;
      DISP_PAGE <= 1'b0;
      DRAW_ADDR <= 32'h0;
      WRADDR    <= 16'h0;
      BYTEEN    <= 4'h0;
      WREN      <= 1'b0;
      WDATA     <= 32'h0;
      RDADDR    <= 16'h0;
      RDEN      <= 1'b0;
    end else begin
      WREN      <= 1'b0;
      RDEN      <= 1'b0;
      FLIP_DONE <= 1'b0;
      if (FLIP_REQ && flip_active) pending <= 1'b1;

      case (state)
        S_IDLE: begin
          if (START) begin
            psz       <= psz_of(RESOL);
            state     <= S_INIT_ADDR;
            phase     <= 2'd0;
            FLIP_BUSY <= 1'b1;
            WREN      <= 1'b1;
            WRADDR    <= REG_DISPADDR;
            BYTEEN    <= 4'b1111;
            WDATA     <= BASE_ADDR;
          end
        end

        S_INIT_ADDR: begin
          if (phase == 2'd0) begin
            phase <= 2'd1;
          end else begin
            state  <= S_INIT_CTRL;
            phase  <= 2'd0;
            WREN   <= 1'b1;
            WRADDR <= REG_DISPCTRL;
            BYTEEN <= 4'b0001;
            WDATA  <= 32'h1;
          end
        end

        S_INIT_CTRL: begin
          if (phase == 2'd0) begin
            phase <= 2'd1;
          end else begin
            state  <= S_INIT_INT;
            phase  <= 2'd0;
            WREN   <= 1'b1;
            WRADDR <= REG_DISPINT;
            BYTEEN <= 4'b0001;
            WDATA  <= 32'h3;
          end
        end

        S_INIT_INT: begin
          if (phase == 2'd0) begin
            phase <= 2'd1;
          end else begin
            state  <= S_INIT_FIFO;
            phase  <= 2'd0;
            WREN   <= 1'b1;
            WRADDR <= REG_DISPFIFO;
            BYTEEN <= 4'b0001;
            WDATA  <= 32'h3;
          end
        end

        S_INIT_FIFO: begin
          if (phase == 2'd0) begin
            phase <= 2'd1;
          end else begin
            state     <= S_READY;
            phase     <= 2'd0;
            FLIP_BUSY <= 1'b0;
            DISP_PAGE <= 1'b0;
            DRAW_ADDR <= page1_addr;
          end
        end

        S_READY: begin
          if (FLIP_REQ || pending) begin
            pending   <= 1'b0;
            state     <= S_CLR_VB;
            phase     <= 2'd0;
            poll_cnt  <= 16'h0;
            FLIP_BUSY <= 1'b1;
            WREN      <= 1'b1;
            WRADDR    <= REG_DISPCTRL;
            BYTEEN    <= 4'b0001;
            WDATA     <= 32'h3;
          end
        end

        S_CLR_VB: begin
          if (phase == 2'd0) begin
            phase <= 2'd1;
          end else begin
            state  <= S_POLL;
            phase  <= 2'd0;
            RDEN   <= 1'b1;
            RDADDR <= REG_DISPCTRL;
          end
        end

        // Read: two RDEN cycles, sample at the end of the second, then one idle cycle.
        S_POLL: begin
          case (phase)
            2'd0: begin
              RDEN  <= 1'b1;
              phase <= 2'd1;
            end
            2'd1: begin
              vb_seen <= RDATA[1];
              if (!RDATA[1]) poll_cnt <= poll_cnt + 16'd1;
              phase <= 2'd2;
            end
            default: begin
              phase <= 2'd0;
              if (vb_seen) begin
                state  <= S_WR_ADDR;
                WREN   <= 1'b1;
                WRADDR <= REG_DISPADDR;
                BYTEEN <= 4'b1111;
                WDATA  <= DISP_PAGE ? BASE_ADDR : page1_addr;
              end else if (poll_cnt >= POLL_MAX) begin
                state     <= S_READY;
                TIMEOUT   <= 1'b1;
                FLIP_BUSY <= 1'b0;
              end else begin
                RDEN <= 1'b1;
              end
            end
          endcase
        end

        S_WR_ADDR: begin
          if (phase == 2'd0) begin
            phase <= 2'd1;
          end else begin
            state <= S_DONE;
            phase <= 2'd0;
          end
        end

        S_DONE: begin
          state     <= S_READY;
          FLIP_BUSY <= 1'b0;
          FLIP_DONE <= 1'b1;
          DISP_PAGE <= ~DISP_PAGE;
          DRAW_ADDR <= DISP_PAGE ? page1_addr : BASE_ADDR;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
